// File: rtl/input_taker_pkg.sv
// +--------------------------------------------------------------------------+
// | input_taker_pkg : shared Simon 32/64 widths, nibble counts, FSM encoding   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package input_taker_pkg;

  localparam int SIMON_N  = 32;
  localparam int SIMON_K  = 64;
  localparam int SIMON_M  = 4;

  localparam int NIB_TEXT = SIMON_N / SIMON_M;
  localparam int NIB_KEY  = SIMON_K / SIMON_M;

  // Raw encodings are shared with the output serializer's bench
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_KEY  = 2'd1;
  localparam logic [1:0] ST_LOAD_TEXT = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LOAD_KEY  = ST_LOAD_KEY,
    LOAD_TEXT = ST_LOAD_TEXT,
    HOLD      = ST_HOLD
  } state_t;

  function automatic logic is_load_state(input state_t s);
    return (s == LOAD_KEY) || (s == LOAD_TEXT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_taker_if.sv
// +--------------------------------------------------------------------------+
// | input_taker_if : nibble input bus plus key/plaintext handoff to the core   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface input_taker_if
  import input_taker_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int K = SIMON_K,
  parameter int M = SIMON_M
);

  logic         start;
  logic         key_load;
  logic         din_valid;
  logic [M-1:0] din;
  logic         consume;
  logic [N-1:0] plaintext;
  logic [K-1:0] key;
  logic         out_valid;
  logic         busy;

  modport master (
    output start, key_load, din_valid, din, consume,
    input  plaintext, key, out_valid, busy
  );

  modport slave (
    input  start, key_load, din_valid, din, consume,
    output plaintext, key, out_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/input_taker_nibble_shift_loader.sv
// +--------------------------------------------------------------------------+
// | nibble_shift_loader : W-bit register with indexed M-bit slice write      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module nibble_shift_loader #(
  parameter int W  = 32,
  parameter int M  = 4,
  parameter int IW = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          wr_en,
  input  wire logic [IW-1:0] wr_idx,
  input  wire logic [M-1:0]  wr_data,
  output logic      [W-1:0]  q
);

  localparam int NIBS = W / M;

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NIBS; i++) begin
        if (wr_idx == IW'(i)) begin
          r_q[i*M +: M] <= wr_data;
        end
      end
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/input_taker.sv
// +--------------------------------------------------------------------------+
// | input_taker : assembles Simon key and plaintext from LSB-first nibbles   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module input_taker
  import input_taker_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int K = SIMON_K,
  parameter int M = SIMON_M
) (
  input wire logic   clk,
  input wire logic   reset,
  input_taker_if.slave bus
);

  localparam int NK    = K / M;
  localparam int NT    = N / M;
  localparam int CNT_W = $clog2(NK) + 1;

  localparam logic [CNT_W-1:0] C_KEY_LAST  = CNT_W'(NK - 1);
  localparam logic [CNT_W-1:0] C_TEXT_LAST = CNT_W'(NT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_key_we;
  logic             w_text_we;
  logic [K-1:0]     w_key;
  logic [N-1:0]     w_text;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= (w_state_next == HOLD);
      r_busy      <= is_load_state(w_state_next);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_key_we     = 1'b0;
    w_text_we    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = bus.key_load ? LOAD_KEY : LOAD_TEXT;
          w_cnt_next   = '0;
        end
      end
      LOAD_KEY: begin
        if (bus.din_valid) begin
          w_key_we = 1'b1;
          if (r_cnt == C_KEY_LAST) begin
            w_state_next = LOAD_TEXT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      LOAD_TEXT: begin
        if (bus.din_valid) begin
          w_text_we = 1'b1;
          if (r_cnt == C_TEXT_LAST) begin
            w_state_next = HOLD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        // A start coinciding with consume chains straight into the next load
        if (bus.consume) begin
          w_cnt_next = '0;
          if (bus.start) begin
            w_state_next = bus.key_load ? LOAD_KEY : LOAD_TEXT;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  nibble_shift_loader #(
    .W  (K),
    .M  (M),
    .IW (CNT_W)
  ) u_key_loader (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_key_we),
    .wr_idx  (r_cnt),
    .wr_data (bus.din),
    .q       (w_key)
  );

  nibble_shift_loader #(
    .W  (N),
    .M  (M),
    .IW (CNT_W)
  ) u_text_loader (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_text_we),
    .wr_idx  (r_cnt),
    .wr_data (bus.din),
    .q       (w_text)
  );

  assign bus.key       = w_key;
  assign bus.plaintext = w_text;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_input_taker.sv
// +--------------------------------------------------------------------------+
// | tb_input_taker : directed-vector bench for input_taker                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_input_taker;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  input_taker_if bus ();

  input_taker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] C_KEY_A  = 64'h1918111009080100;
  localparam logic [31:0] C_TEXT_A = 32'h65656877;
  localparam logic [63:0] C_KEY_B  = 64'hFEDCBA9876543210;

  // Advance one edge and settle; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nibble(input logic [3:0] n);
    bus.din_valid = 1'b1;
    bus.din       = n;
    tick();
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
  endtask

  task automatic pulse_start(input logic kl);
    bus.start    = 1'b1;
    bus.key_load = kl;
    tick();
    bus.start    = 1'b0;
    bus.key_load = 1'b0;
  endtask

  task automatic pulse_consume();
    bus.consume = 1'b1;
    tick();
    bus.consume = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_vec++;
    if (bus.key !== 64'h0) begin
      n_miss++; $display("FAIL reset_key got %h exp %h", bus.key, 64'h0);
    end
    n_vec++;
    if (bus.plaintext !== 32'h0) begin
      n_miss++; $display("FAIL reset_text got %h exp %h", bus.plaintext, 32'h0);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL reset_flags got ov=%b busy=%b exp ov=0 busy=0", bus.out_valid, bus.busy);
    end
    // consume with nothing held must do nothing
    pulse_consume();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL idle_consume got ov=%b busy=%b exp ov=0 busy=0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_key_text();
    logic [3:0] kn [16] = '{4'h0,4'h0,4'h1,4'h0,4'h8,4'h0,4'h9,4'h0,4'h0,4'h1,4'h1,4'h1,4'h8,4'h1,4'h9,4'h1};
    logic [3:0] tn [8]  = '{4'h7,4'h7,4'h8,4'h6,4'h5,4'h6,4'h5,4'h6};
    pulse_start(1'b1);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_miss++; $display("FAIL kt_busy_start got %b exp 1", bus.busy);
    end
    for (int i = 0; i < 16; i++) drive_nibble(kn[i]);
    n_vec++;
    if (bus.key !== C_KEY_A) begin
      n_miss++; $display("FAIL kt_key_after_load got %h exp %h", bus.key, C_KEY_A);
    end
    for (int i = 0; i < 7; i++) drive_nibble(tn[i]);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_miss++; $display("FAIL kt_before_last got ov=%b busy=%b exp ov=0 busy=1", bus.out_valid, bus.busy);
    end
    drive_nibble(tn[7]);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL kt_out_valid got ov=%b busy=%b exp ov=1 busy=0", bus.out_valid, bus.busy);
    end
    n_vec++;
    if (bus.key !== C_KEY_A) begin
      n_miss++; $display("FAIL kt_key got %h exp %h", bus.key, C_KEY_A);
    end
    n_vec++;
    if (bus.plaintext !== C_TEXT_A) begin
      n_miss++; $display("FAIL kt_text got %h exp %h", bus.plaintext, C_TEXT_A);
    end
  endtask

  task automatic test_text_reload();
    pulse_consume();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL tr_consume got ov=%b busy=%b exp ov=0 busy=0", bus.out_valid, bus.busy);
    end
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) drive_nibble(4'(i));
    n_vec++;
    if (bus.key !== C_KEY_A) begin
      n_miss++; $display("FAIL tr_key got %h exp %h", bus.key, C_KEY_A);
    end
    n_vec++;
    if (bus.plaintext !== 32'h76543210 || bus.out_valid !== 1'b1) begin
      n_miss++; $display("FAIL tr_text got %h ov=%b exp %h ov=1", bus.plaintext, bus.out_valid, 32'h76543210);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] tn [8] = '{4'h7,4'h7,4'h8,4'h6,4'h5,4'h6,4'h5,4'h6};
    pulse_consume();
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_nibble(tn[i]);
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          bus.din_valid = 1'b0;
          bus.din       = 4'hF - 4'(g);
          tick();
          n_vec++;
          if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_miss++; $display("FAIL gap_busy[%0d] got busy=%b ov=%b exp busy=1 ov=0", i, bus.busy, bus.out_valid);
          end
        end
      end
    end
    bus.din = 4'h0;
    n_vec++;
    if (bus.plaintext !== C_TEXT_A || bus.out_valid !== 1'b1) begin
      n_miss++; $display("FAIL gap_text got %h ov=%b exp %h ov=1", bus.plaintext, bus.out_valid, C_TEXT_A);
    end
    n_vec++;
    if (bus.key !== C_KEY_A) begin
      n_miss++; $display("FAIL gap_key got %h exp %h", bus.key, C_KEY_A);
    end
  endtask

  task automatic test_reset_mid();
    pulse_consume();
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) drive_nibble(4'hA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (bus.key !== 64'h0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_miss++; $display("FAIL rm_after_reset got key=%h busy=%b ov=%b exp key=0 busy=0 ov=0", bus.key, bus.busy, bus.out_valid);
    end
    // still idle: stray nibbles must be ignored
    drive_nibble(4'h5);
    n_vec++;
    if (bus.key !== 64'h0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL rm_idle_din got key=%h busy=%b exp key=0 busy=0", bus.key, bus.busy);
    end
    pulse_start(1'b1);
    for (int i = 0; i < 16; i++) drive_nibble(4'(i));
    for (int i = 8; i < 16; i++) drive_nibble(4'(i));
    n_vec++;
    if (bus.key !== C_KEY_B) begin
      n_miss++; $display("FAIL rm_key got %h exp %h", bus.key, C_KEY_B);
    end
    n_vec++;
    if (bus.plaintext !== 32'hFEDCBA98 || bus.out_valid !== 1'b1) begin
      n_miss++; $display("FAIL rm_text got %h ov=%b exp %h ov=1", bus.plaintext, bus.out_valid, 32'hFEDCBA98);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tn [8] = '{4'hA,4'hB,4'hC,4'hD,4'h1,4'h2,4'h3,4'h4};
    bus.consume  = 1'b1;
    bus.start    = 1'b1;
    bus.key_load = 1'b0;
    tick();
    bus.consume  = 1'b0;
    bus.start    = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_miss++; $display("FAIL b2b_chain got ov=%b busy=%b exp ov=0 busy=1", bus.out_valid, bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      // start (with and without key_load) mid-load must neither restart nor recount
      bus.start    = (i % 2 == 1);
      bus.key_load = (i == 3);
      drive_nibble(tn[i]);
      if (i == 2) begin
        bus.start    = 1'b1;
        bus.key_load = 1'b1;
        tick();
      end
      bus.start    = 1'b0;
      bus.key_load = 1'b0;
    end
    n_vec++;
    if (bus.plaintext !== 32'h4321DCBA || bus.out_valid !== 1'b1) begin
      n_miss++; $display("FAIL b2b_text got %h ov=%b exp %h ov=1", bus.plaintext, bus.out_valid, 32'h4321DCBA);
    end
    n_vec++;
    if (bus.key !== C_KEY_B) begin
      n_miss++; $display("FAIL b2b_key got %h exp %h", bus.key, C_KEY_B);
    end
  endtask

  task automatic test_hold_stability();
    for (int c = 0; c < 20; c++) begin
      bus.din_valid = 1'b1;
      bus.din       = 4'($urandom_range(0, 15));
      bus.start     = c[0];
      bus.key_load  = c[1];
      tick();
      n_vec++;
      if (bus.plaintext !== 32'h4321DCBA || bus.key !== C_KEY_B || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
        n_miss++;
        $display("FAIL hold[%0d] got pt=%h key=%h ov=%b busy=%b exp pt=%h key=%h ov=1 busy=0",
                 c, bus.plaintext, bus.key, bus.out_valid, bus.busy, 32'h4321DCBA, C_KEY_B);
      end
    end
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
    bus.start     = 1'b0;
    bus.key_load  = 1'b0;
    pulse_consume();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL hold_release got ov=%b busy=%b exp ov=0 busy=0", bus.out_valid, bus.busy);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.key_load  = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
    bus.consume   = 1'b0;
    test_reset();
    test_key_text();
    test_text_reload();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    test_hold_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
